vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Single-clock arbiter sharing one VRAM port (registered-read sysMEM, 1-cycle read latency, synchronous write) between the display fetch engine and the CPU data port.
- Holds off all access for a boot-wait interval after reset, because initialised sysMEM is not reliably readable immediately after configuration.
- Display has strict priority; the CPU is serviced in idle slots.
- Sits between the CPU register interface, the video timing/fetch logic and the VRAM block.

Parameters:
- VRAM_SIZE, 4096, VRAM depth in bytes; AW = $clog2(VRAM_SIZE).
- BOOT_WAIT, 16, cycles after reset release before the first grant.
- MAX_CPU_WAIT, 8, starvation limit; used only with VRAM_ARB_FAIR_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  boot wait complete; arbiter is granting.
- disp_req  in  1  display fetch request; held until granted.
- disp_addr  in  AW  display fetch address.
- disp_gnt  out  1  display access issued this cycle.
- disp_valid  out  1  disp_data valid (one cycle after disp_gnt).
- disp_data  out  8  read data, passed through from mem_rdata.
- cpu_req  in  1  CPU access request; held, with its qualifiers, until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata updated.
- cpu_rdata  out  8  last CPU read result (registered, held).
- mem_addr  out  AW  VRAM address.
- mem_we  out  1  VRAM write enable.
- mem_wdata  out  8  VRAM write data.
- mem_rdata  in  8  VRAM registered read data.

Behaviour:
- Reset (clk, reset synchronous, active-high): state=BOOT; boot counter loaded with BOOT_WAIT-1; starvation counter=0; ready=0.
- Outputs under reset: disp_gnt=0, cpu_gnt=0, disp_valid=0, cpu_rvalid=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States:
  - BOOT: decrement the counter each cycle; at 0 go to RUN. The first grant is possible in reset-release cycle + BOOT_WAIT. BOOT_WAIT=0 is illegal; assert in simulation.
  - RUN: ready=1.
- Requests seen in BOOT are not granted and not lost; the requester keeps holding them.
- Grant, RUN only, combinational on the current request lines:
  - disp_gnt = disp_req and not forced_cpu.
  - cpu_gnt = cpu_req and not disp_gnt.
  - At most one grant per cycle.
- mem_addr/mem_we/mem_wdata mux:
  - disp_gnt: disp_addr, we=0.
  - cpu_gnt: cpu_addr, we=cpu_we, wdata=cpu_wdata.
  - Otherwise: mem_we=0; mem_addr/mem_wdata hold their previous value.
- Latency:
  - Grant in cycle N gives data in N+1: disp_valid=1 and disp_data=mem_rdata in N+1.
  - A CPU read granted in N: cpu_rvalid pulses in N+1 and cpu_rdata captures mem_rdata at the end of N+1.
  - CPU writes: no rvalid; memory is updated at the edge ending N.
- Back-to-back grants every cycle are supported with no bubbles.
- Read-after-write to the same address in consecutive cycles returns the new data; the memory is write-first.
- Simultaneous requests: display wins; the CPU waits, holding its request.
- A request dropped before grant is legal and produces no side effects.
- Reset asserted mid-access: the pending rvalid/valid is cancelled; return to BOOT with the full BOOT_WAIT.

Optional Feature:
- VRAM_ARB_FAIR_EN defined:
  - Starvation counter increments each RUN cycle in which cpu_req=1 and cpu_gnt=0; it saturates at MAX_CPU_WAIT.
  - forced_cpu = (counter == MAX_CPU_WAIT); this grants the CPU over the display for one cycle.
  - The counter clears on cpu_gnt or when cpu_req=0.
- Not defined: forced_cpu is tied to 0 and the counter is not built; display has strict priority and the CPU may starve indefinitely.

Decomposition:
- Package vram_arb_pkg holds:
  - State enum {BOOT, RUN}.
  - Owner enum {NONE, DISP, CPU}, used to route the registered return path.
  - Data width constant 8.
- One natural sub-module: boot_wait_timer (load, count down, done flag). It is reusable for other sysMEM consumers.

Test Plan:
- Reset, with disp_req and cpu_req held high from cycle 0, BOOT_WAIT=16 -> ready rises and the first disp_gnt occurs exactly 16 cycles after reset deassertion; no grant before then.
- Preload VRAM[0x123]=0xA5, CPU read 0x123 with no display traffic -> cpu_gnt in N, cpu_rvalid in N+1, cpu_rdata=0xA5 held afterwards.
- CPU write 0x040<-0x3C, then display read 0x040 the next cycle -> disp_valid with disp_data=0x3C.
- Both requesters high continuously, feature off -> disp_gnt every cycle, cpu_gnt never, mem_we never 1.
- Same as the previous test with VRAM_ARB_FAIR_EN, MAX_CPU_WAIT=8 -> cpu_gnt once every 9th cycle with disp_gnt=0 in that cycle; the display resumes the next cycle.
- Reset pulsed in the cycle after a CPU read grant -> no cpu_rvalid; cpu_rdata=0; ready=0 for BOOT_WAIT cycles.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the VRAM arbiter slice.
// Optional feature macro used by this slice: VRAM_ARB_FAIR_EN.
package vram_arb_pkg;

    localparam int unsigned DATA_W = 32'd8;

    // Arbiter top-level state.
    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // Owner of the access issued last cycle; steers the registered read return.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, CPU and VRAM bus signals around the arbiter.
// slave = arbiter side, master = requesters and memory side.
interface vram_arbiter_if #(
    parameter int AW = 12
);
    import vram_arb_pkg::*;

    logic              ready;
    logic              disp_req;
    logic [AW-1:0]     disp_addr;
    logic              disp_gnt;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        output ready, disp_gnt, disp_valid, disp_data,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata
    );

    modport master (
        input  ready, disp_gnt, disp_valid, disp_data,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/vram_arbiter_boot_wait_timer.sv
// boot_wait_timer: loads WAIT-1 on load, counts down to zero and holds there.
// done is high while the count is zero. Reusable by any sysMEM consumer
// that must wait after configuration before its first read.
module boot_wait_timer #(
    parameter int unsigned WAIT = 16
) (
    input  logic clk,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = (WAIT > 32'd1) ? $clog2(WAIT) : 32'd1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT - 32'd1);

    logic [CW-1:0] count_r;

    // Reload on load, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            count_r <= LOAD_VAL;
        end else if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {CW{1'b0}});

endmodule

// File: rtl/vram_arbiter_checker.sv
// vram_arbiter_checker: simulation-time checks on arbiter configuration
// and the one-grant-per-cycle property.
module vram_arbiter_checker #(
    parameter int unsigned BOOT_WAIT    = 16,
    parameter int unsigned MAX_CPU_WAIT = 8
) (
    input logic clk,
    input logic reset,
    input logic disp_gnt,
    input logic cpu_gnt
);

    // Flag illegal parameters and simultaneous grants every cycle.
    always @(posedge clk) begin
        assert (BOOT_WAIT != 32'd0)
            else $error("vram_arbiter: BOOT_WAIT must be nonzero");
        assert (MAX_CPU_WAIT != 32'd0)
            else $error("vram_arbiter: MAX_CPU_WAIT must be nonzero");
        if (!reset) begin
            assert (!(disp_gnt && cpu_gnt))
                else $error("vram_arbiter: two grants in one cycle");
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one registered-read VRAM port between the display
// fetch engine (priority) and the CPU. Grants are withheld for BOOT_WAIT
// cycles after reset. Define VRAM_ARB_FAIR_EN to force a CPU slot after
// MAX_CPU_WAIT consecutive waiting cycles.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned VRAM_SIZE    = 4096,
    parameter int unsigned BOOT_WAIT    = 16,
    parameter int unsigned MAX_CPU_WAIT = 8
) (
    input logic          clk,
    input logic          reset,
    vram_arbiter_if.slave bus
);

    localparam int unsigned AW = $clog2(VRAM_SIZE);
    localparam logic [0:0] S_BOOT = BOOT;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]        state_r;
    logic              boot_done_s;
    logic              run_s;
    logic              forced_cpu_s;
    logic              disp_gnt_s;
    logic              cpu_gnt_s;
    owner_e            owner_r;
    logic [AW-1:0]     mem_addr_s;
    logic [AW-1:0]     mem_addr_r;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r;

    boot_wait_timer #(.WAIT(BOOT_WAIT)) u_boot_timer (
        .clk  (clk),
        .load (reset),
        .done (boot_done_s)
    );

    vram_arbiter_checker #(.BOOT_WAIT(BOOT_WAIT), .MAX_CPU_WAIT(MAX_CPU_WAIT)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .disp_gnt (disp_gnt_s),
        .cpu_gnt  (cpu_gnt_s)
    );

    // BOOT until the wait timer expires, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_BOOT;
        end else begin
            case (state_r)
                S_BOOT:  state_r <= boot_done_s ? S_RUN : S_BOOT;
                S_RUN:   state_r <= S_RUN;
                default: state_r <= S_BOOT;
            endcase
        end
    end

    // A reset cycle never grants, even if the state register still says RUN.
    assign run_s = (state_r == S_RUN) && !reset;

`ifdef VRAM_ARB_FAIR_EN
    localparam int unsigned SW = (MAX_CPU_WAIT > 32'd0) ? $clog2(MAX_CPU_WAIT + 32'd1) : 32'd1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CPU_WAIT);

    logic [SW-1:0] starve_r;

    // Count RUN cycles in which the CPU waits; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_r <= {SW{1'b0}};
        end else if (!bus.cpu_req || cpu_gnt_s) begin
            starve_r <= {SW{1'b0}};
        end else if (run_s && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_r <= starve_r;
        end
    end

    assign forced_cpu_s = run_s && (starve_r == STARVE_MAX);
`else
    assign forced_cpu_s = 1'b0;
`endif

    // Display first unless the CPU is being forced through; CPU otherwise.
    always_comb begin
        disp_gnt_s = 1'b0;
        cpu_gnt_s  = 1'b0;
        if (run_s) begin
            disp_gnt_s = bus.disp_req && !forced_cpu_s;
            cpu_gnt_s  = bus.cpu_req && !disp_gnt_s;
        end else begin
            disp_gnt_s = 1'b0;
            cpu_gnt_s  = 1'b0;
        end
    end

    // Steer the granted requester onto the VRAM port; hold address/data when idle.
    always_comb begin
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_we_s    = 1'b0;
        if (reset) begin
            mem_addr_s  = {AW{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end else if (disp_gnt_s) begin
            mem_addr_s  = bus.disp_addr;
        end else if (cpu_gnt_s) begin
            mem_addr_s  = bus.cpu_addr;
            mem_we_s    = bus.cpu_we;
            mem_wdata_s = bus.cpu_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Remember the last driven address/data so idle cycles hold them.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // Record who owns the read data returning next cycle (writes return nothing).
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= OWN_NONE;
        end else if (disp_gnt_s) begin
            owner_r <= OWN_DISP;
        end else if (cpu_gnt_s && !bus.cpu_we) begin
            owner_r <= OWN_CPU;
        end else begin
            owner_r <= OWN_NONE;
        end
    end

    // Capture CPU read data at the end of its return cycle; hold it afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_r <= {DATA_W{1'b0}};
        end else if (owner_r == OWN_CPU) begin
            cpu_rdata_r <= bus.mem_rdata;
        end else begin
            cpu_rdata_r <= cpu_rdata_r;
        end
    end

    assign bus.ready      = run_s;
    assign bus.disp_gnt   = disp_gnt_s;
    assign bus.cpu_gnt    = cpu_gnt_s;
    assign bus.disp_valid = (owner_r == OWN_DISP) && !reset;
    assign bus.cpu_rvalid = (owner_r == OWN_CPU) && !reset;
    assign bus.disp_data  = bus.mem_rdata;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed bench for vram_arbiter with a behavioural
// write-first, registered-read VRAM. Expectations follow VRAM_ARB_FAIR_EN.
module tb_vram_arbiter;

    localparam int unsigned BOOT_WAIT = 16;
`ifdef VRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [7:0] vram [0:4095];

    vram_arbiter_if #(.AW(12)) bus ();

    vram_arbiter #(.VRAM_SIZE(4096), .BOOT_WAIT(BOOT_WAIT), .MAX_CPU_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: preload while reset is high, else write-first registered read.
    always @(posedge clk) begin
        if (reset) begin
            vram[12'h123] <= 8'hA5;
            vram[12'h200] <= 8'h5A;
        end else if (bus.mem_we) begin
            vram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : vram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic exp_cpu;
    logic prev_disp;
    logic prev_cpu;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'h200;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 12'h300;
        bus.cpu_wdata = 8'h00;
        prev_disp = 1'b0;
        prev_cpu  = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_disp_gnt", 32'(bus.disp_gnt), 32'd0);
        check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Boot wait with both requests held
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("boot_ready", 32'(bus.ready), 32'd0);
            check("boot_disp_gnt", 32'(bus.disp_gnt), 32'd0);
            check("boot_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
            next_cycle();
        end

        // Continuous contention: display every cycle, CPU every 9th with fairness
        for (int j = 0; j < 27; j++) begin
            @(negedge clk);
            exp_cpu = FAIR && ((j % 9) == 8);
            check("run_ready", 32'(bus.ready), 32'd1);
            check("run_disp_gnt", 32'(bus.disp_gnt), 32'(!exp_cpu));
            check("run_cpu_gnt", 32'(bus.cpu_gnt), 32'(exp_cpu));
            check("run_mem_we", 32'(bus.mem_we), 32'd0);
            check("run_mem_addr", 32'(bus.mem_addr), exp_cpu ? 32'h300 : 32'h200);
            if (j > 0) begin
                check("run_disp_valid", 32'(bus.disp_valid), 32'(prev_disp));
                check("run_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(prev_cpu));
                if (prev_disp) check("run_disp_data", 32'(bus.disp_data), 32'h5A);
            end
            prev_disp = !exp_cpu;
            prev_cpu  = exp_cpu;
            next_cycle();
        end

        // Requests dropped: no grant, address holds
        bus.disp_req = 1'b0;
        bus.cpu_req  = 1'b0;
        @(negedge clk);
        check("idle_disp_gnt", 32'(bus.disp_gnt), 32'd0);
        check("idle_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("idle_mem_we", 32'(bus.mem_we), 32'd0);
        check("idle_mem_addr_hold", 32'(bus.mem_addr), FAIR ? 32'h300 : 32'h200);
        next_cycle();

        // CPU read of preloaded 0x123
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h123;
        @(negedge clk);
        check("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("rd_disp_gnt", 32'(bus.disp_gnt), 32'd0);
        check("rd_mem_addr", 32'(bus.mem_addr), 32'h123);
        check("rd_mem_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("rd_gnt_off", 32'(bus.cpu_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rd_rvalid_off", 32'(bus.cpu_rvalid), 32'd0);
        check("rd_rdata", 32'(bus.cpu_rdata), 32'hA5);
        next_cycle();

        // CPU write 0x040 <- 0x3C, then display read of 0x040
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 12'h040;
        bus.cpu_wdata = 8'h3C;
        @(negedge clk);
        check("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h040);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
        next_cycle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'h040;
        @(negedge clk);
        check("raw_disp_gnt", 32'(bus.disp_gnt), 32'd1);
        check("raw_mem_we", 32'(bus.mem_we), 32'd0);
        check("raw_mem_addr", 32'(bus.mem_addr), 32'h040);
        check("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        next_cycle();
        bus.disp_req = 1'b0;
        @(negedge clk);
        check("raw_disp_valid", 32'(bus.disp_valid), 32'd1);
        check("raw_disp_data", 32'(bus.disp_data), 32'h3C);
        check("raw_rdata_held", 32'(bus.cpu_rdata), 32'hA5);
        next_cycle();

        // CPU read granted, then reset in the following cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 12'h040;
        @(negedge clk);
        check("rr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rr_rvalid_cancel", 32'(bus.cpu_rvalid), 32'd0);
        check("rr_ready", 32'(bus.ready), 32'd0);
        check("rr_mem_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        reset       = 1'b0;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("rr_boot_ready", 32'(bus.ready), 32'd0);
            check("rr_boot_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
            check("rr_boot_rdata", 32'(bus.cpu_rdata), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("rr_ready_up", 32'(bus.ready), 32'd1);
        check("rr_first_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rr_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("rr_rdata", 32'(bus.cpu_rdata), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
